// File: rtl/uart_log_rx.sv
// UART 8N1 receiver plus fixed-length event-frame decoder (sync, ID, start/end ts, delta, XOR checksum).
// Good frames are re-presented on a valid/ready output register; errors are reported as 1-cycle pulses.
module uart_log_rx #(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 1_000_000,
    parameter int ID_W   = 16,
    parameter int TS_W   = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rx,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ID_W-1:0] out_id,
    output logic [TS_W-1:0] out_start_ts,
    output logic [TS_W-1:0] out_end_ts,
    output logic [TS_W-1:0] out_delta,
    output logic            frame_err,
    output logic            chk_err,
    output logic            overrun
);

    localparam int CPB  = CLK_HZ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam int FW   = ID_W + 3 * TS_W;
    localparam int NB   = FW / 8;
    localparam int IW   = $clog2(NB + 1);

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_e;
    typedef enum logic [1:0] {F_HUNT, F_FIELDS, F_CHK} fstate_e;

    logic            rx_meta_q, rx_sync_q;
    logic [1:0]      warm_q, warm_d;
    logic            armed_q, armed_d;
    bstate_e         bstate_q, bstate_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      byte_q, byte_d;
    logic            byte_done_q, byte_done_d;
    logic            frame_err_q, frame_err_d;

    fstate_e         fstate_q, fstate_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [7:0]      xor_q, xor_d;
    logic [FW-1:0]   fields_q, fields_d;
    logic            out_valid_q, out_valid_d;
    logic [ID_W-1:0] out_id_q, out_id_d;
    logic [TS_W-1:0] out_start_q, out_start_d;
    logic [TS_W-1:0] out_end_q, out_end_d;
    logic [TS_W-1:0] out_delta_q, out_delta_d;
    logic            chk_err_q, chk_err_d;
    logic            overrun_q, overrun_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            warm_q      <= '0;
            armed_q     <= 1'b0;
            bstate_q    <= B_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            byte_q      <= '0;
            byte_done_q <= 1'b0;
            frame_err_q <= 1'b0;
            fstate_q    <= F_HUNT;
            idx_q       <= '0;
            xor_q       <= '0;
            fields_q    <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_start_q <= '0;
            out_end_q   <= '0;
            out_delta_q <= '0;
            chk_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_sync_q   <= rx_meta_q;
            warm_q      <= warm_d;
            armed_q     <= armed_d;
            bstate_q    <= bstate_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            byte_q      <= byte_d;
            byte_done_q <= byte_done_d;
            frame_err_q <= frame_err_d;
            fstate_q    <= fstate_d;
            idx_q       <= idx_d;
            xor_q       <= xor_d;
            fields_q    <= fields_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_start_q <= out_start_d;
            out_end_q   <= out_end_d;
            out_delta_q <= out_delta_d;
            chk_err_q   <= chk_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Byte FSM. IDLE only arms once the flushed synchronizer shows the line high, so a
    // line already low at reset release is not mistaken for a start edge.
    always_comb begin
        warm_d      = {warm_q[0], 1'b1};
        armed_d     = armed_q;
        bstate_d    = bstate_q;
        cnt_d       = cnt_q + 1'b1;
        bit_d       = bit_q;
        shift_d     = shift_q;
        byte_d      = byte_q;
        byte_done_d = 1'b0;
        frame_err_d = 1'b0;
        case (bstate_q)
            B_IDLE: begin
                cnt_d = '0;
                if (warm_q[1] && rx_sync_q) begin
                    armed_d = 1'b1;
                end
                if (armed_q && !rx_sync_q) begin
                    armed_d  = 1'b0;
                    bstate_d = B_START;
                end
            end
            B_START: begin
                if (cnt_q == CW'(HALF - 1)) begin
                    cnt_d    = '0;
                    bit_d    = '0;
                    bstate_d = rx_sync_q ? B_IDLE : B_DATA;
                end
            end
            B_DATA: begin
                if (cnt_q == CW'(CPB - 1)) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
                        bstate_d = B_STOP;
                    end
                end
            end
            B_STOP: begin
                if (cnt_q == CW'(CPB - 1)) begin
                    cnt_d    = '0;
                    bstate_d = B_IDLE;
                    if (rx_sync_q) begin
                        byte_done_d = 1'b1;
                        byte_d      = shift_q;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: bstate_d = B_IDLE;
        endcase
    end

    always_comb begin
        fstate_d    = fstate_q;
        idx_d       = idx_q;
        xor_d       = xor_q;
        fields_d    = fields_q;
        out_valid_d = out_valid_q && !out_ready;
        out_id_d    = out_id_q;
        out_start_d = out_start_q;
        out_end_d   = out_end_q;
        out_delta_d = out_delta_q;
        chk_err_d   = 1'b0;
        overrun_d   = 1'b0;
        if (frame_err_q && fstate_q != F_HUNT) begin
            fstate_d = F_HUNT;
        end else if (byte_done_q) begin
            case (fstate_q)
                F_HUNT: begin
                    if (byte_q == 8'hA5) begin
                        fstate_d = F_FIELDS;
                        idx_d    = '0;
                        xor_d    = '0;
                    end
                end
                F_FIELDS: begin
                    fields_d = {fields_q[FW-9:0], byte_q};
                    xor_d    = xor_q ^ byte_q;
                    idx_d    = idx_q + 1'b1;
                    if (idx_q == IW'(NB - 1)) begin
                        fstate_d = F_CHK;
                    end
                end
                F_CHK: begin
                    fstate_d = F_HUNT;
                    if (byte_q != xor_q) begin
                        chk_err_d = 1'b1;
                    end else if (out_valid_q && !out_ready) begin
                        overrun_d = 1'b1;
                    end else begin
                        // A transfer this cycle frees the register, so load wins over it.
                        out_valid_d = 1'b1;
                        out_id_d    = fields_q[FW-1 -: ID_W];
                        out_start_d = fields_q[3*TS_W-1 -: TS_W];
                        out_end_d   = fields_q[2*TS_W-1 -: TS_W];
                        out_delta_d = fields_q[TS_W-1:0];
                    end
                end
                default: fstate_d = F_HUNT;
            endcase
        end
    end

    assign out_valid    = out_valid_q;
    assign out_id       = out_id_q;
    assign out_start_ts = out_start_q;
    assign out_end_ts   = out_end_q;
    assign out_delta    = out_delta_q;
    assign frame_err    = frame_err_q;
    assign chk_err      = chk_err_q;
    assign overrun      = overrun_q;

endmodule

// File: doc/uart_log_rx.md
# uart_log_rx

UART receive-side frame decoder for the event logger link. Deserializes the 8N1 byte stream produced by the UART logger and validates each fixed-length event frame (sync, ID, start/end timestamps, delta, checksum). Re-presents each good frame on a valid/ready bus with the same field layout the logger consumes. Used for on-board TX→RX loopback self-check and as the checker endpoint in simulation.

## Interface
Parameters:
- CLK_HZ, 100_000_000, system clock frequency.
- BAUD, 1_000_000, line rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer, ≥ 8).
- ID_W, 16, event ID width; multiple of 8.
- TS_W, 64, timestamp/delta width; multiple of 8.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous UART line, idle high.
- out_valid  out  1  decoded frame available.
- out_ready  in  1  downstream accepts frame.
- out_id  out  ID_W  event ID.
- out_start_ts  out  TS_W  start timestamp.
- out_end_ts  out  TS_W  end timestamp.
- out_delta  out  TS_W  delta field as received; not recomputed.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- chk_err  out  1  one-cycle pulse: checksum mismatch.
- overrun  out  1  one-cycle pulse: good frame dropped because the output register was still full.

## Operation
- Frame byte order: 0xA5 sync, ID (ID_W/8 bytes), start_ts, end_ts, delta (TS_W/8 bytes each), checksum. Multi-byte fields MSB first. Defaults give 28 bytes.
- Checksum = XOR of every byte between sync and checksum, exclusive of both.
- rx input: 2-FF synchronizer, both stages reset to 1. All logic uses the synchronized value.
- Byte FSM (bit counter plus CLKS_PER_BIT tick counter):
  - IDLE: on synchronized rx = 0, go to START.
  - START: wait CLKS_PER_BIT/2 cycles, then resample. If 0, go to DATA. If 1, treat as a glitch and return to IDLE with no error.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - STOP: sample after CLKS_PER_BIT cycles. If 1, emit byte_done. If 0, pulse frame_err, discard the byte, go to IDLE.
- Frame FSM, advanced on byte_done:
  - HUNT: byte 0xA5 → FIELDS with byte index cleared and running XOR cleared. Any other byte is ignored.
  - FIELDS: shift the byte into the field register and XOR it into the running checksum. After the last delta byte, go to CHK. Payload bytes equal to 0xA5 carry no special meaning; parsing is count-based.
  - CHK: next byte is the checksum.
    - Match and output empty → load output registers, set out_valid.
    - Match and output full → pulse overrun, keep held frame.
    - Mismatch → pulse chk_err.
    - Return to HUNT in all three cases.
- frame_err while in FIELDS or CHK aborts the frame: frame FSM returns to HUNT; partial data is never presented.
- Output handshake: transfer when out_valid && out_ready. The out_* fields are stable while out_valid && !out_ready. out_valid clears the cycle after transfer unless a new frame loads that same cycle. On a simultaneous load and transfer, load wins and out_valid stays 1.

## Timing
- Reset values: out_valid=0, out_id=0, out_start_ts=0, out_end_ts=0, out_delta=0, frame_err=0, chk_err=0, overrun=0. Byte FSM = IDLE, frame FSM = HUNT.
- Reset mid-byte or mid-frame discards everything. The first byte accepted after reset must be preceded by a falling edge seen in IDLE.
- Synchronizer latency: 2 cycles.
- Sample points: start bit sampled CLKS_PER_BIT/2 after the falling edge is detected. Data bit n sampled (n+1)·CLKS_PER_BIT after that. Stop bit sampled 9·CLKS_PER_BIT after that.
- byte_done is registered 1 cycle after the stop-bit sample.
- out_valid (or chk_err/overrun) rises 1 cycle after byte_done of the checksum byte.
- Error pulses are exactly 1 cycle wide, and at most one of chk_err/overrun fires per frame.
- Back-to-back bytes with zero idle are required to work. The byte FSM re-arms in IDLE at mid-stop-bit, so the next start edge is caught.
- Throughput: one frame per 28·10·CLKS_PER_BIT cycles (28 000 at defaults). Sustained rate needs out_ready asserted at least once per frame.

## Test plan
- Good frame, defaults, ID=0x0001, start=0x10, end=0x35, delta=0x25, checksum 0x01, out_ready=1 → one out_valid pulse with exactly those fields; no error pulses.
- Same frame with checksum byte 0x00 → chk_err single pulse, out_valid stays 0. A following good frame is then decoded normally.
- Stop bit of byte 5 forced low → frame_err pulse; no output. The next frame, including a payload byte equal to 0xA5, decodes correctly.
- Two good frames back-to-back, out_ready=0 throughout → first frame held stable, overrun pulses once at the end of frame 2. Raising out_ready → frame 1 transferred and out_valid falls next cycle.
- 30-cycle low glitch on idle rx, then a good frame → no error or byte from the glitch; frame decoded.
- rst asserted mid-frame (byte 12) for 1 cycle, line continues with remaining bytes then a full good frame → outputs at reset values until the full frame; only that frame is presented.
